// File: rtl/mult_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl_pkg
// Shared constants for the EX-stage multiply/divide sequencer:
//   - FSM state encoding (IDLE/MUL/DIV/DONE)
//   - iteration counter width for the default 32-bit datapath
//   - LO value written on divide-by-zero
//   - function codes the unit decodes, plus a decode helper
// -----------------------------------------------------------------------------
package mult_div_ctrl_pkg;

    localparam int unsigned MD_DATA_W  = 32;
    localparam int unsigned ITER_CNT_W = $clog2(MD_DATA_W);

    // LO result for any divide with a zero divisor
    localparam logic [MD_DATA_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Function codes handled by this unit
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // True for the four multi-cycle operations
    function automatic logic is_mul_div(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_ctrl_div_step.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl_div_step
// One combinational restoring-divide step.
// Ports:
//   rem_in   in  DATA_W+1  partial remainder already shifted left with the
//                          next dividend bit appended
//   divisor  in  DATA_W    divisor magnitude
//   rem_out  out DATA_W    next partial remainder
//   q_bit    out 1         quotient bit produced by this step
// -----------------------------------------------------------------------------
module mult_div_ctrl_div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W+1:0] diff;
    logic [DATA_W:0]   sel;
    logic              unused_sel_msb;

    // Extra top bit carries the borrow: set means the divisor did not fit
    assign diff  = {1'b0, rem_in} - {2'b00, divisor};
    assign q_bit = ~diff[DATA_W+1];
    assign sel   = q_bit ? diff[DATA_W:0] : rem_in;

    // Remainder is always below the divisor, so the top bit is zero here
    assign rem_out        = sel[DATA_W-1:0];
    assign unused_sel_msb = sel[DATA_W];

endmodule

// File: rtl/mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl
// Multi-cycle multiply/divide sequencer for the EX stage. Runs an iterative
// shift-add multiply or restoring divide (DATA_W iterations), holds the
// pipeline with stall_req, then commits to the architectural HI/LO registers.
// Also services MFHI/MFLO reads and MTHI/MTLO writes.
//
// Build option: define MULT_DIV_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle DATA_W x DATA_W multiplier (divide is unchanged).
//
// Ports:
//   clk        in  1       system clock
//   rst_n      in  1       asynchronous active-low reset
//   en         in  1       EX instruction targets this unit
//   funct      in  6       function code
//   operand_1  in  DATA_W  rs: dividend / multiplicand / MT source
//   operand_2  in  DATA_W  rt: divisor / multiplier
//   flush      in  1       pipeline flush, aborts an operation in flight
//   stall_req  out 1       hold upstream pipeline
//   done       out 1       one-cycle pulse after HI/LO updated by MULT/DIV
//   hi         out DATA_W  HI register
//   lo         out DATA_W  LO register
//   result     out DATA_W  MFHI/MFLO read data, else 0
// -----------------------------------------------------------------------------
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic              flush,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    // acc: product high half (MUL) or partial remainder (DIV)
    logic [DATA_W-1:0] acc_q, acc_d;
    // shr: multiplier shifting out (MUL) or dividend shifting into quotient (DIV)
    logic [DATA_W-1:0] shr_q, shr_d;
    // opb: multiplicand (MUL) or divisor (DIV) magnitude
    logic [DATA_W-1:0] opb_q, opb_d;
    // neg: product/quotient sign; dvd_neg: dividend sign (remainder sign)
    logic              neg_q, neg_d;
    logic              dvd_neg_q, dvd_neg_d;

    // ---------------------------------------------------------------- decode
    logic              accept;
    logic              is_div;
    logic              is_signed;
    logic              sign_1, sign_2;
    logic [DATA_W-1:0] mag_1, mag_2;
    logic              busy;
    logic              last_iter;

    assign accept    = en && (state_q == ST_IDLE) && is_mul_div(funct);
    assign is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign sign_1    = is_signed & operand_1[DATA_W-1];
    assign sign_2    = is_signed & operand_2[DATA_W-1];
    assign mag_1     = sign_1 ? -operand_1 : operand_1;
    assign mag_2     = sign_2 ? -operand_2 : operand_2;
    assign last_iter = (count_q == CNT_W'(DATA_W - 1));

    // ------------------------------------------------------ multiply datapath
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_prod;
    logic [2*DATA_W-1:0] mul_prod_fix;

    assign mul_sum      = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
    // Shift the sum right into the multiplier as its LSB is consumed
    assign mul_prod     = {mul_sum, shr_q[DATA_W-1:1]};
    assign mul_prod_fix = neg_q ? -mul_prod : mul_prod;

`ifdef MULT_DIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_mag;
    logic [2*DATA_W-1:0] fast_prod;

    assign fast_mag  = {{DATA_W{1'b0}}, mag_1} * {{DATA_W{1'b0}}, mag_2};
    assign fast_prod = (sign_1 ^ sign_2) ? -fast_mag : fast_mag;
`endif

    // -------------------------------------------------------- divide datapath
    logic [DATA_W-1:0] div_rem;
    logic              div_q_bit;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_quo_fix;
    logic [DATA_W-1:0] div_rem_fix;
    logic [DATA_W-1:0] dvd_raw;

    mult_div_ctrl_div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_in  ({acc_q, shr_q[DATA_W-1]}),
        .divisor (opb_q),
        .rem_out (div_rem),
        .q_bit   (div_q_bit)
    );

    assign div_quo     = {shr_q[DATA_W-2:0], div_q_bit};
    assign div_quo_fix = neg_q ? -div_quo : div_quo;
    assign div_rem_fix = dvd_neg_q ? -div_rem : div_rem;
    // Before the first step shr still holds the dividend magnitude; re-applying
    // the sign recovers the operand bits as originally presented
    assign dvd_raw     = dvd_neg_q ? -shr_q : shr_q;

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        shr_d     = shr_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        dvd_neg_d = dvd_neg_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!flush) begin
                        count_d   = '0;
                        acc_d     = '0;
                        neg_d     = sign_1 ^ sign_2;
                        dvd_neg_d = sign_1;
                        if (is_div) begin
                            shr_d   = mag_1;
                            opb_d   = mag_2;
                            state_d = ST_DIV;
                        end else begin
`ifdef MULT_DIV_FAST_MUL_EN
                            {hi_d, lo_d} = fast_prod;
                            state_d      = ST_DONE;
`else
                            shr_d   = mag_2;
                            opb_d   = mag_1;
                            state_d = ST_MUL;
`endif
                        end
                    end
                end else if (en && (funct == FUNCT_MTHI)) begin
                    hi_d = operand_1;
                end else if (en && (funct == FUNCT_MTLO)) begin
                    lo_d = operand_1;
                end
            end

            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = mul_prod[2*DATA_W-1:DATA_W];
                    shr_d   = mul_prod[DATA_W-1:0];
                    count_d = count_q + 1'b1;
                    if (last_iter) begin
                        {hi_d, lo_d} = mul_prod_fix;
                        state_d      = ST_DONE;
                    end
                end
            end

            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if ((count_q == '0) && (opb_q == '0)) begin
                    hi_d    = dvd_raw;
                    lo_d    = {DATA_W{1'b1}};
                    state_d = ST_DONE;
                end else begin
                    acc_d   = div_rem;
                    shr_d   = div_quo;
                    count_d = count_q + 1'b1;
                    if (last_iter) begin
                        hi_d    = div_rem_fix;
                        lo_d    = div_quo_fix;
                        state_d = ST_DONE;
                    end
                end
            end

            // HI/LO already committed; flush cannot undo them
            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            shr_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            shr_q     <= shr_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            dvd_neg_q <= dvd_neg_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign busy      = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
    assign stall_req = busy && !flush;
    assign done      = (state_q == ST_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        result = '0;
        if (en && (funct == FUNCT_MFHI)) begin
            result = hi_q;
        end else if (en && (funct == FUNCT_MFLO)) begin
            result = lo_q;
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: a table of MULT/DIV vectors with
// hand-computed HI/LO and latency, plus sequences for MT/MF, flush and reset.
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

`ifdef MULT_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int total;
    int bad;

    mult_div_ctrl #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to the drive point just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  k;
        int  stalls;
        bit  seen;
        en        = 1'b1;
        funct     = v.f;
        operand_1 = v.a;
        operand_2 = v.b;
        #3;
        chk($sformatf("v%0d stall_at_accept", idx), {31'b0, stall_req}, 32'd1);
        stalls = 1;
        tick();
        en        = 1'b0;
        funct     = 6'h0;
        operand_1 = '0;
        operand_2 = '0;
        k    = 1;
        seen = 1'b0;
        while (k <= 100 && !seen) begin
            #3;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall_req) stalls++;
                tick();
                k++;
            end
        end
        chk($sformatf("v%0d done_seen", idx), {31'b0, seen}, 32'd1);
        if (seen) begin
            chk($sformatf("v%0d done_latency", idx), k, v.lat);
            chk($sformatf("v%0d stall_cycles", idx), stalls, v.lat);
            chk($sformatf("v%0d stall_in_done", idx), {31'b0, stall_req}, 32'd0);
            chk($sformatf("v%0d hi", idx), hi, v.exp_hi);
            chk($sformatf("v%0d lo", idx), lo, v.exp_lo);
            tick();
            #3;
            chk($sformatf("v%0d done_single_pulse", idx), {31'b0, done}, 32'd0);
        end
        tick();
    endtask

    initial begin
        int  seen_done;

        total = 0;
        bad   = 0;

        vecs[0] = '{FUNCT_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1] = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[2] = '{FUNCT_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT};
        vecs[3] = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[4] = '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
        vecs[5] = '{FUNCT_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 2};
        vecs[6] = '{FUNCT_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
        vecs[7] = '{FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
        vecs[8] = '{FUNCT_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 2};

        rst_n     = 1'b0;
        en        = 1'b0;
        funct     = 6'h0;
        operand_1 = '0;
        operand_2 = '0;
        flush     = 1'b0;
        #12;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset stall_req", {31'b0, stall_req}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // MTHI / MTLO then read back
        en = 1'b1; funct = FUNCT_MTHI; operand_1 = 32'h0000_1234;
        tick();
        funct = FUNCT_MTLO; operand_1 = 32'h0000_5678;
        tick();
        funct = FUNCT_MFHI; operand_1 = '0;
        #3;
        chk("mfhi result", result, 32'h0000_1234);
        tick();
        funct = FUNCT_MFLO;
        #3;
        chk("mflo result", result, 32'h0000_5678);
        tick();
        en = 1'b0;
        #3;
        chk("result idle zero", result, 32'd0);
        tick();

        // DIV 50/7 with an ignored MTHI while busy, flushed at T+10
        en = 1'b1; funct = FUNCT_DIVU; operand_1 = 32'd50; operand_2 = 32'd7;
        tick();                                    // T+1
        funct = FUNCT_MTHI; operand_1 = 32'hDEAD_BEEF;
        tick();                                    // T+2
        en = 1'b0; funct = 6'h0; operand_1 = '0; operand_2 = '0;
        #3;
        chk("busy stall_req", {31'b0, stall_req}, 32'd1);
        chk("mthi ignored while busy", hi, 32'h0000_1234);
        tick();                                    // T+3
        repeat (7) tick();                         // T+10
        flush = 1'b1;
        #3;
        chk("flush cycle stall_req", {31'b0, stall_req}, 32'd0);
        tick();                                    // T+11
        flush = 1'b0;
        #3;
        chk("after flush stall_req", {31'b0, stall_req}, 32'd0);
        chk("after flush hi", hi, 32'h0000_1234);
        chk("after flush lo", lo, 32'h0000_5678);
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #3;
            if (done) seen_done++;
        end
        chk("no done after flush", seen_done, 0);
        tick();

        // Flush coinciding with an accept
        en = 1'b1; funct = FUNCT_MULT; operand_1 = 32'd3; operand_2 = 32'd5; flush = 1'b1;
        #3;
        chk("flush at accept stall_req", {31'b0, stall_req}, 32'd0);
        tick();
        en = 1'b0; funct = 6'h0; flush = 1'b0; operand_1 = '0; operand_2 = '0;
        #3;
        chk("flush at accept next stall", {31'b0, stall_req}, 32'd0);
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #3;
            if (done) seen_done++;
        end
        chk("flush at accept no done", seen_done, 0);
        chk("flush at accept hi kept", hi, 32'h0000_1234);
        tick();

        // Reset in the middle of a MULT
        en = 1'b1; funct = FUNCT_MULT; operand_1 = 32'd7; operand_2 = 32'hFFFF_FFFD;
        tick();
        en = 1'b0; funct = 6'h0; operand_1 = '0; operand_2 = '0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop reset hi", hi, 32'd0);
        chk("midop reset lo", lo, 32'd0);
        chk("midop reset stall_req", {31'b0, stall_req}, 32'd0);
        chk("midop reset done", {31'b0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #3;
            if (done || stall_req) seen_done++;
        end
        chk("post reset idle", seen_done, 0);

        // Unit still works after everything above
        tick();
        run_vec(99, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
